uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the team's 16x-oversampled transmitter; shares the same baud_tick generator.
- Synchronizes the asynchronous rx line and detects start bits with a false-start filter.
- Samples each bit at mid-bit, framed LSB first as 1 start, DATA_BITS data, 1 stop.
- Presents the received byte in a one-entry holding register with a valid/ready handshake, plus framing-error and overrun pulses.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
OVERSAMPLE, 16, baud_tick pulses per bit period (even, >= 4)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
baud_tick  input  1  single-cycle enable pulse at OVERSAMPLE x baud rate
rx  input  1  serial line, asynchronous to clk, idles high
rx_ready  input  1  consumer accepts rx_data this cycle when rx_valid=1
rx_data  output  DATA_BITS  received data, stable while rx_valid=1
rx_valid  output  1  holding register contains an unconsumed byte
frame_err_tick  output  1  one-cycle pulse: stop bit sampled low
overrun_tick  output  1  one-cycle pulse: good frame discarded because holding register full

Behaviour:
- Reset (reset_n low, async, any time incl. mid-frame):
  - state=idle; tick counter s=0; bit counter n=0; shift register=0.
  - rx_data=0, rx_valid=0, frame_err_tick=0, overrun_tick=0.
  - Both synchronizer flops=1.
- Synchronizer: rx passes through 2 flops -> rx_s; all FSM decisions use rx_s only (2-cycle input latency).
- FSM counting: s advances only on cycles with baud_tick=1; no other cycle changes s or n.
- idle:
  - While rx_s=1, stay in idle.
  - On rx_s=0 (any cycle, tick not required): go to start, s=0.
- start:
  - On baud_tick with s == OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0 -> data, s=0, n=0.
    - rx_s=1 -> false start, back to idle; no outputs.
  - Other baud_tick: s=s+1.
- data:
  - On baud_tick with s == OVERSAMPLE-1: shift rx_s into MSB of shift register (right shift, LSB first), s=0.
    - If n == DATA_BITS-1 -> stop; else n=n+1.
  - Other baud_tick: s=s+1.
- stop:
  - On baud_tick with s == OVERSAMPLE-1: sample rx_s, go to idle, s=0.
  - Other baud_tick: s=s+1.
  - Remaining half stop bit is absorbed in idle; rx_s must be high there.
- Frame completion (the stop-sample cycle), registered so outputs change on that clock edge:
  - rx_s=0: frame_err_tick=1 for one cycle; rx_data and rx_valid unchanged.
  - rx_s=1 and (rx_valid=0 or rx_ready=1): rx_data<=shift register, rx_valid<=1.
  - rx_s=1 and rx_valid=1 and rx_ready=0: overrun_tick=1 for one cycle; new byte discarded, rx_data keeps the old byte.
- Handshake:
  - rx_valid=1 and rx_ready=1 with no completion that cycle -> rx_valid<=0 next edge.
  - Completion and consume in the same cycle -> new byte loaded, rx_valid stays 1, no overrun.
  - rx_ready is ignored while rx_valid=0.
- Latency: from the rx falling edge at the pin to rx_valid is ~(1 + DATA_BITS + 0.5) bit periods + 2-3 clk.
- frame_err_tick and overrun_tick are never asserted together. Neither is ever asserted outside a stop-sample cycle.
- Back-to-back frames: a start edge immediately after the stop mid-point is accepted (idle re-arms the cycle it is entered).

Test Plan:
- Bench: baud_tick every 4 clk, OVERSAMPLE=16, DATA_BITS=8.
- Frame 0xA5, valid stop, rx_ready=1 -> rx_valid high exactly 1 clk with rx_data=0xA5; frame_err_tick=overrun_tick=0 throughout.
- rx low for 4 baud_ticks then high (glitch), followed by frame 0x3C -> no output for glitch; FSM back in idle before the real frame; then rx_data=0x3C, rx_valid=1.
- Frame 0x55 with stop bit driven 0, prior rx_data=0x3C held (rx_ready=0) -> frame_err_tick 1-clk pulse; rx_data stays 0x3C; rx_valid unchanged.
- rx_ready=0, send 0x11 then 0x22 -> rx_valid=1, rx_data=0x11; overrun_tick 1-clk pulse at 0x22 stop sample; rx_data remains 0x11; raise rx_ready 1 clk -> rx_valid=0 next edge.
- Assert reset_n=0 during data bit 3 of frame 0x96, release, send 0xFF -> all outputs 0 during reset; no 0x96 output; then rx_data=0xFF, rx_valid=1.
- Back-to-back 0x00 then 0xFF with one stop bit, no idle gap, rx_ready=1 -> two rx_valid pulses with 0x00 then 0xFF; no errors.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver with 16x (parameterisable) oversampling. The asynchronous rx
//   line is double-flopped. A falling edge of the synchronised line arms the
//   receiver. The start bit is re-checked at its mid-point, which rejects
//   glitches shorter than half a bit. Data bits are sampled mid-bit, LSB first,
//   and then the stop bit is sampled. A good frame is loaded into a one-entry
//   holding register with a valid/ready handshake. A bad stop bit produces a
//   framing-error pulse. A good frame that arrives while the holding register
//   is still full is dropped and produces an overrun pulse.
//
// Ports
//   clk             system clock; all logic runs on its rising edge
//   reset_n         asynchronous active-low reset
//   baud_tick       one-cycle enable pulse at OVERSAMPLE x baud rate
//   rx              serial input; asynchronous to clk; idles high
//   rx_ready        consumer takes rx_data in a cycle where rx_valid=1
//   rx_data         received word; held stable while rx_valid=1
//   rx_valid        holding register contains an unconsumed word
//   frame_err_tick  one-cycle pulse: the stop bit was sampled low
//   overrun_tick    one-cycle pulse: a good frame was lost to a full holding reg
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,   // 5..8
  parameter int unsigned OVERSAMPLE = 16   // even, >= 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err_tick,
  output logic                 overrun_tick
);

  localparam int unsigned S_W = $clog2(OVERSAMPLE);
  localparam int unsigned N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_END  = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e               state_q;
  logic [S_W-1:0]       s_q;        // baud ticks elapsed in the current bit
  logic [N_W-1:0]       n_q;        // index of the data bit being received
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  // Data arrives LSB first. Shifting right from the top leaves the first bit
  // in bit 0 once all DATA_BITS have been shifted in.
  assign shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};

  // Two-flop synchroniser. The FSM only ever looks at rx_s_q.
  // NOTE: both flops reset to the idle-line level (1). A reset value of 0 would
  // look like a start edge as soon as reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM with registered outputs.
  // NOTE: every state element is assigned with <= only. All right-hand sides
  // therefore see the values from before the edge, independent of statement
  // order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consume. A completion later in this block overrides the clear.
      // NOTE: when several <= target the same register in one block, the last
      // one executed wins. A load in the stop-sample cycle therefore keeps
      // rx_valid high even if the old word is consumed in that same cycle.
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          // Re-armed on entry, so a start edge that follows the stop mid-point
          // immediately is still caught.
          if (!rx_s_q) begin
            state_q <= ST_START;
            s_q     <= '0;
          end
        end

        ST_START: begin
          if (baud_tick) begin
            if (s_q == S_MID) begin
              s_q <= '0;
              if (!rx_s_q) begin
                state_q <= ST_DATA;
                n_q     <= '0;
              end else begin
                state_q <= ST_IDLE;  // line went high again: glitch, ignore
              end
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            if (s_q == S_END) begin
              s_q     <= '0;
              shift_q <= shift_d;
              if (n_q == N_LAST) begin
                state_q <= ST_STOP;
              end else begin
                n_q <= n_q + N_W'(1);
              end
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end

        ST_STOP: begin
          if (baud_tick) begin
            if (s_q == S_END) begin
              s_q     <= '0;
              state_q <= ST_IDLE;
              if (!rx_s_q) begin
                frame_err_q <= 1'b1;
              end else if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign frame_err_tick = frame_err_q;
  assign overrun_tick   = overrun_q;

endmodule
